fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the RISC-V core. It owns the program counter and issues word requests to instruction memory. It holds each fetched instruction and its PC for the decode stage, which holds the immediate generator. It also accepts PC redirects for taken branches, JAL and JALR, whose targets come from the immediate-based next-PC logic downstream.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; word aligned.
- NOP_INSTR, 32'h0000_0013, value driven on if_instruction when nothing valid (addi x0,x0,0).

- clk  in  1  rising-edge clock, single clock domain.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; held until imem_ack.
- imem_addr  out  32  byte address of requested word; stable while imem_req high.
- imem_ack  in  1  response valid this cycle; legal in the same cycle as imem_req or any later cycle.
- imem_rdata  in  32  instruction word, sampled only when imem_ack=1.
- if_valid  out  1  if_instruction/if_pc hold a live instruction.
- if_instruction  out  32  fetched instruction to decode.
- if_pc  out  32  address of if_instruction.
- id_ready  in  1  decode consumes the instruction on a cycle with if_valid && id_ready.
- redirect_valid  in  1  load redirect_pc as next fetch address; discards in-flight and held instructions.
- redirect_pc  in  32  redirect target.
- fetch_fault  out  1  sticky misaligned-redirect flag; present only with FETCH_MISALIGN_TRAP_EN, otherwise tied 0.

## Operation
- State register with states FETCH, HOLD, DRAIN, HALT. The PC register pc is internal.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack: if_instruction<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4 (mod 2^32, wraps 0xFFFF_FFFC→0), go to HOLD.
- HOLD:
  - imem_req=0; outputs stable.
  - On id_ready: if_valid<=0, if_instruction<=NOP_INSTR, go to FETCH.
- DRAIN:
  - imem_req=1 with the stale imem_addr held.
  - On imem_ack: the response is discarded, go to FETCH.
- Redirect (highest priority, any state except HALT):
  - pc<=redirect_pc, if_valid<=0, if_instruction<=NOP_INSTR.
  - Next state is DRAIN if a request is outstanding this cycle (state FETCH or DRAIN and imem_ack=0), otherwise FETCH.
  - A redirect with imem_ack=1 in the same cycle discards that response and goes to FETCH.
- Redirect in HOLD together with id_ready: the held instruction counts as consumed; the redirect still applies.
- Redirect while in DRAIN: pc is updated and the state stays DRAIN.
- The imem_addr driven in DRAIN is latched separately from pc, so a redirect never alters an outstanding request's address.
- Throughput: at most one instruction per two cycles (FETCH→HOLD→FETCH).

## Timing
- Reset (synchronous, cycle with reset=1):
  - pc<=RESET_PC, state<=FETCH.
  - if_valid<=0, if_instruction<=NOP_INSTR, if_pc<=0, fetch_fault<=0.
  - imem_req is gated low while reset=1.
- First request: imem_req=1, imem_addr=RESET_PC in the first cycle after reset deasserts.
- Latency: if_valid rises on the clock edge that samples imem_ack. With zero-wait memory, if_valid is high 1 cycle after the request cycle.
- imem_req/imem_addr are combinational from registered state only; they do not depend on imem_ack or id_ready.
- Reset mid-request: the outstanding request is abandoned. The memory must drop a pending ack on reset.
- Redirect takes effect on the next edge. The first request to the target appears the cycle after the redirect (FETCH path) or the cycle after the draining ack (DRAIN path).

## Configuration
- FETCH_MISALIGN_TRAP_EN:
  - Defined: a redirect with redirect_pc[1:0]!=0 sets fetch_fault<=1, clears if_valid and enters HALT. The DRAIN rules apply first if a request is outstanding. HALT holds imem_req=0 and ignores redirects until reset.
  - Undefined: redirect_pc[1:0] is forced to 2'b00, fetch_fault is constant 0, and HALT is unreachable.

## Test plan
- Reset with RESET_PC=0, zero-wait memory returning addr+0x100, id_ready=1 -> if_pc sequence 0,4,8; if_instruction 0x100,0x104,0x108; if_valid every other cycle.
- id_ready=0 for 5 cycles after first fetch -> if_valid, if_pc=0 and if_instruction held; imem_req=0 throughout; the next request to 0x4 starts only after id_ready=1.
- Memory with 3-cycle latency; redirect_pc=0x80 one cycle after request to 0x4 -> imem_addr stays 0x4 until ack; response dropped (if_valid stays 0); next request is 0x80.
- Redirect to 0x200 in the same cycle as imem_ack -> no if_valid pulse for that word; next imem_addr=0x200.
- pc=0xFFFF_FFFC fetch -> next imem_addr=0x0000_0000.
- With FETCH_MISALIGN_TRAP_EN, redirect_pc=0x102 -> fetch_fault=1 next cycle, imem_req=0 forever, later redirects ignored. Without the macro -> next imem_addr=0x100, fetch_fault=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word requests to instruction memory and
// holds one fetched instruction for decode. Optional misaligned-redirect trap: FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {StFetch, StHold, StDrain, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        valid_q, valid_d;
  logic        outstanding;
  logic        redirect_take;
  logic [31:0] target;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q, fault_d;
  logic misaligned;
`endif

  always_comb begin
    outstanding = ((state_q == StFetch) || (state_q == StDrain)) && !imem_ack;
`ifdef FETCH_MISALIGN_TRAP_EN
    target        = redirect_pc;
    misaligned    = (redirect_pc[1:0] != 2'b00);
    // Once a fault is pending, redirects are ignored just as in HALT.
    redirect_take = redirect_valid && (state_q != StHalt) && !fault_q;
`else
    target        = redirect_pc & 32'hFFFF_FFFC;
    redirect_take = redirect_valid && (state_q != StHalt);
`endif
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    if_pc_d      = if_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    fault_d      = fault_q;
`endif
    if (redirect_take) begin
      pc_d    = target;
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      if (outstanding) begin
        state_d = StDrain;
        // Freeze the in-flight address; a redirect while already draining keeps it.
        if (state_q == StFetch) drain_addr_d = pc_q;
      end else begin
        state_d = StFetch;
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      if (misaligned) begin
        fault_d = 1'b1;
        if (!outstanding) state_d = StHalt;
      end
`endif
    end else begin
      case (state_q)
        StFetch: begin
          if (imem_ack) begin
            instr_d = imem_rdata;
            if_pc_d = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
            state_d = StHold;
          end
        end
        StHold: begin
          if (id_ready) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            state_d = StFetch;
          end
        end
        StDrain: begin
          if (imem_ack) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            state_d = fault_q ? StHalt : StFetch;
`else
            state_d = StFetch;
`endif
          end
        end
        StHalt:  state_d = StHalt;
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      drain_addr_q <= 32'h0;
      valid_q      <= 1'b0;
      instr_q      <= NOP_INSTR;
      if_pc_q      <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      if_pc_q      <= if_pc_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

  assign imem_req       = !reset && ((state_q == StFetch) || (state_q == StDrain));
  assign imem_addr      = (state_q == StDrain) ? drain_addr_q : pc_q;
  assign if_valid       = valid_q;
  assign if_instruction = instr_q;
  assign if_pc          = if_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Table-driven bench for fetch_unit: one row per clock cycle of inputs and expected outputs,
// plus a hand-written zero-wait throughput sequence.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  int total = 0;
  int bad   = 0;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit Trap = 1'b1;
`else
  localparam bit Trap = 1'b0;
`endif
  localparam logic [31:0] Nop = 32'h0000_0013;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instruction (if_instruction),
    .if_pc          (if_pc),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_fault;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic ack, input logic [31:0] rdata,
                              input logic rdy, input logic rv, input logic [31:0] rpc,
                              input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                              input logic [31:0] e_instr, input logic [31:0] e_pc,
                              input logic e_fault);
    vec_t v;
    v.rst = rst; v.ack = ack; v.rdata = rdata; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_instr = e_instr;
    v.e_pc = e_pc; v.e_fault = e_fault;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic ack, input logic [31:0] rdata,
                       input logic rdy, input logic rv, input logic [31:0] rpc);
    reset = rst; imem_ack = ack; imem_rdata = rdata; id_ready = rdy;
    redirect_valid = rv; redirect_pc = rpc;
  endtask

  initial begin
    //  rst ack rdata          rdy rv rpc            req addr           vld instr          pc            flt
    // zero-wait fetches, memory returns addr+0x100
    add(0, 1, 32'h100,        1, 0, 0,             1, 32'h0,          0, Nop,           32'h0,        0);
    add(0, 0, 0,              1, 0, 0,             0, 0,              1, 32'h100,       32'h0,        0);
    add(0, 1, 32'h104,        1, 0, 0,             1, 32'h4,          0, Nop,           32'h0,        0);
    add(0, 0, 0,              1, 0, 0,             0, 0,              1, 32'h104,       32'h4,        0);
    add(0, 1, 32'h108,        0, 0, 0,             1, 32'h8,          0, Nop,           32'h4,        0);
    // decode stalls 5 cycles: instruction held, no requests
    for (int i = 0; i < 5; i++)
      add(0, 0, 0,            0, 0, 0,             0, 0,              1, 32'h108,       32'h8,        0);
    add(0, 0, 0,              1, 0, 0,             0, 0,              1, 32'h108,       32'h8,        0);
    // slow memory; redirect to 0x80 while request to 0xC is outstanding
    add(0, 0, 0,              1, 0, 0,             1, 32'hC,          0, Nop,           32'h8,        0);
    add(0, 0, 0,              1, 1, 32'h80,        1, 32'hC,          0, Nop,           32'h8,        0);
    add(0, 0, 0,              1, 0, 0,             1, 32'hC,          0, Nop,           32'h8,        0);
    add(0, 1, 32'hDEAD,       1, 0, 0,             1, 32'hC,          0, Nop,           32'h8,        0);
    // redirect during DRAIN keeps the draining address, retargets the PC
    add(0, 0, 0,              1, 1, 32'h40,        1, 32'h80,         0, Nop,           32'h8,        0);
    add(0, 0, 0,              1, 1, 32'h300,       1, 32'h80,         0, Nop,           32'h8,        0);
    add(0, 1, 32'hBEEF,       1, 0, 0,             1, 32'h80,         0, Nop,           32'h8,        0);
    add(0, 1, 32'h777,        0, 0, 0,             1, 32'h300,        0, Nop,           32'h8,        0);
    // redirect in HOLD together with id_ready
    add(0, 0, 0,              1, 1, 32'h500,       0, 0,              1, 32'h777,       32'h300,      0);
    // redirect in the same cycle as the ack drops that word
    add(0, 1, 32'h999,        1, 1, 32'h200,       1, 32'h500,        0, Nop,           32'h300,      0);
    add(0, 0, 0,              1, 0, 0,             1, 32'h200,        0, Nop,           32'h300,      0);
    // PC wrap at top of address space
    add(0, 1, 32'h1,          1, 1, 32'hFFFF_FFFC, 1, 32'h200,        0, Nop,           32'h300,      0);
    add(0, 1, 32'hABC,        1, 0, 0,             1, 32'hFFFF_FFFC,  0, Nop,           32'h300,      0);
    add(0, 0, 0,              1, 0, 0,             0, 0,              1, 32'hABC,       32'hFFFF_FFFC, 0);
    add(0, 0, 0,              1, 0, 0,             1, 32'h0,          0, Nop,           32'hFFFF_FFFC, 0);
    // misaligned redirect to 0x102
    add(0, 1, 32'h2,          1, 1, 32'h102,       1, 32'h0,          0, Nop,           32'hFFFF_FFFC, 0);
    add(0, 0, 0,              1, 0, 0,             !Trap, 32'h100,    0, Nop,           32'hFFFF_FFFC, Trap);
    add(0, 0, 0,              1, 1, 32'h40,        !Trap, 32'h100,    0, Nop,           32'hFFFF_FFFC, Trap);
    add(0, 0, 0,              1, 0, 0,             !Trap, 32'h100,    0, Nop,           32'hFFFF_FFFC, Trap);
    // reset while a request is outstanding
    add(1, 0, 0,              1, 0, 0,             0, 0,              0, Nop,           32'hFFFF_FFFC, Trap);
    add(0, 0, 0,              1, 0, 0,             1, 32'h0,          0, Nop,           32'h0,        0);

    drive(1, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ack, vecs[i].rdata, vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
      #1;
      chk($sformatf("row%0d imem_req", i), {31'b0, imem_req}, {31'b0, vecs[i].e_req});
      if (vecs[i].e_req) chk($sformatf("row%0d imem_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("row%0d if_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].e_valid});
      chk($sformatf("row%0d if_instruction", i), if_instruction, vecs[i].e_instr);
      chk($sformatf("row%0d if_pc", i), if_pc, vecs[i].e_pc);
      chk($sformatf("row%0d fetch_fault", i), {31'b0, fetch_fault}, {31'b0, vecs[i].e_fault});
      @(negedge clk);
    end

    // hand-written sequence: one instruction per two cycles from reset
    drive(1, 0, 0, 1, 0, 0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      logic [31:0] a;
      a = 32'(4 * k);
      drive(0, 1, a + 32'h100, 1, 0, 0);
      #1;
      chk($sformatf("seq%0d req", k), {31'b0, imem_req}, 32'd1);
      chk($sformatf("seq%0d addr", k), imem_addr, a);
      chk($sformatf("seq%0d idle valid", k), {31'b0, if_valid}, 32'd0);
      @(negedge clk);
      drive(0, 0, 0, 1, 0, 0);
      #1;
      chk($sformatf("seq%0d valid", k), {31'b0, if_valid}, 32'd1);
      chk($sformatf("seq%0d instr", k), if_instruction, a + 32'h100);
      chk($sformatf("seq%0d pc", k), if_pc, a);
      chk($sformatf("seq%0d hold req", k), {31'b0, imem_req}, 32'd0);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
